// File: rtl/multiword_add_seq.sv
// Sequential wide adder: one WORD_W-bit carry-lookahead slice per clock, LSB slice first,
// with the inter-slice carry held in a register. One operation in flight at a time.
module multiword_add_seq #(
    parameter int WORD_W = 8,
    parameter int NSLICE = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_W*NSLICE-1:0]   a,
    input  logic [WORD_W*NSLICE-1:0]   b,
    input  logic                       cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_W*NSLICE-1:0]   sum,
    output logic                       cout,
    output logic                       ovf,
    output logic                       busy
);

    localparam int W     = WORD_W * NSLICE;
    localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [WORD_W-1:0]  a_slice;
    logic [WORD_W-1:0]  b_slice;
    logic [WORD_W-1:0]  gen;
    logic [WORD_W-1:0]  prop;
    logic [WORD_W:0]    chain;
    logic [WORD_W-1:0]  slice_sum;

    // A transfer happens on a rising edge where valid and ready are both high; valid,
    // once raised, must hold with stable data until that edge. Ready never depends on valid.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (idx == LAST_IDX) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Carry chain written as the g/p recurrence; it flattens into lookahead logic per slice.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) begin
                a_slice = a_q[i*WORD_W +: WORD_W];
                b_slice = b_q[i*WORD_W +: WORD_W];
            end
        end
        gen      = a_slice & b_slice;
        prop     = a_slice ^ b_slice;
        chain    = '0;
        chain[0] = carry;
        for (int i = 0; i < WORD_W; i++) begin
            chain[i+1] = gen[i] | (prop[i] & chain[i]);
        end
        slice_sum = prop ^ chain[WORD_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (idx == IDX_W'(i)) sum[i*WORD_W +: WORD_W] <= slice_sum;
                    end
                    carry <= chain[WORD_W];
                    // Final slice: its MSB carries decide signed overflow of the whole word.
                    if (idx == LAST_IDX) begin
                        cout <= chain[WORD_W];
                        ovf  <= chain[WORD_W-1] ^ chain[WORD_W];
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
